// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit -- machine-mode control/status register block.
//
// Holds the M-mode CSRs (mstatus, misa, mtvec, mscratch, mepc, mcause and the
// 64-bit mcycle/minstret counters). It executes CSR instructions as they
// commit, takes traps and MRETs, and issues pipeline redirects.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   commit_valid/ready  commit handshake (ready only in RUN)
//   commit_pc           PC of the committing instruction
//   is_csr, csr_op,
//   csr_addr, rs1_idx,
//   rs1_val             CSR instruction fields and operand
//   exception_valid,
//   exception_cause     trap request for the committing instruction
//   is_mret             committing instruction is MRET
//   current_privilege   privilege of the committing instruction
//   csr_rdata           old CSR value for rd (combinational)
//   csr_illegal         access to an unimplemented CSR (combinational)
//   mstatus             live mstatus value
//   exception, mret_out one-cycle trap / MRET pulses
//   redirect_valid/pc   flush and fetch target
// ---------------------------------------------------------------------------
module csr_unit #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_MTVEC = DATA_WIDTH'(32'h0000_0100)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_valid,
    output logic                  commit_ready,
    input  logic [DATA_WIDTH-1:0] commit_pc,
    input  logic                  is_csr,
    input  logic [2:0]            csr_op,
    input  logic [11:0]           csr_addr,
    input  logic [4:0]            rs1_idx,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    input  logic                  exception_valid,
    input  logic [DATA_WIDTH-1:0] exception_cause,
    input  logic                  is_mret,
    input  logic [1:0]            current_privilege,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_illegal,
    output logic [DATA_WIDTH-1:0] mstatus,
    output logic                  exception,
    output logic                  mret_out,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    localparam int                    CNT_W    = 2 * DATA_WIDTH;
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] MISA_VAL = DATA_WIDTH'(32'h4000_1100);
    localparam logic [DATA_WIDTH-1:0] ALIGN4   = ~DATA_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic                    mie_reg, mpie_reg;
    logic [1:0]              mpp_reg;
    logic [DATA_WIDTH-1:0]   mtvec_reg, mscratch_reg, mepc_reg, mcause_reg;
    logic [CNT_W-1:0]        mcycle_reg, mcycle_next;
    logic [CNT_W-1:0]        minstret_reg, minstret_next;

    logic                    accept;
    logic                    implemented;
    logic [DATA_WIDTH-1:0]   read_data;
    logic [DATA_WIDTH-1:0]   operand;
    logic [DATA_WIDTH-1:0]   write_data;
    logic                    op_valid;
    logic                    write_en;

    assign accept = commit_valid && (state_reg == ST_RUN);

    // Only MIE, MPIE and MPP exist; everything else reads as zero.
    always_comb begin
        mstatus        = '0;
        mstatus[3]     = mie_reg;
        mstatus[7]     = mpie_reg;
        mstatus[12:11] = mpp_reg;
    end

    // Address decode and read mux.
    always_comb begin
        read_data   = '0;
        implemented = 1'b1;
        case (csr_addr)
            12'h300: read_data = mstatus;
            12'h301: read_data = MISA_VAL;
            12'h305: read_data = mtvec_reg;
            12'h340: read_data = mscratch_reg;
            12'h341: read_data = mepc_reg;
            12'h342: read_data = mcause_reg;
            12'hB00: read_data = mcycle_reg[DATA_WIDTH-1:0];
            12'hB80: read_data = mcycle_reg[CNT_W-1:DATA_WIDTH];
            12'hB02: read_data = minstret_reg[DATA_WIDTH-1:0];
            12'hB82: read_data = minstret_reg[CNT_W-1:DATA_WIDTH];
            default: implemented = 1'b0;
        endcase
    end

    // funct3[2] selects the zero-extended immediate, funct3[1:0] the operation.
    assign operand = csr_op[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx} : rs1_val;

    always_comb begin
        write_data = read_data;
        op_valid   = 1'b1;
        case (csr_op[1:0])
            2'b01:   write_data = operand;
            2'b10:   write_data = read_data | operand;
            2'b11:   write_data = read_data & ~operand;
            default: op_valid   = 1'b0;
        endcase
    end

    // Set/clear forms with a zero source register are pure reads.
    assign write_en = accept && is_csr && !exception_valid && implemented && op_valid
                      && ((csr_op[1:0] == 2'b01) || (rs1_idx != 5'd0));

    assign csr_illegal = accept && is_csr && !exception_valid && !implemented;
    assign csr_rdata   = (accept && is_csr && implemented) ? read_data : '0;

    // Counters: a write to one half replaces it and suppresses that cycle's
    // increment; the other half holds.
    always_comb begin
        mcycle_next   = mcycle_reg + CNT_ONE;
        minstret_next = minstret_reg;
        if (accept && !exception_valid)
            minstret_next = minstret_reg + CNT_ONE;
        if (write_en) begin
            case (csr_addr)
                12'hB00: mcycle_next   = {mcycle_reg[CNT_W-1:DATA_WIDTH], write_data};
                12'hB80: mcycle_next   = {write_data, mcycle_reg[DATA_WIDTH-1:0]};
                12'hB02: minstret_next = {minstret_reg[CNT_W-1:DATA_WIDTH], write_data};
                12'hB82: minstret_next = {write_data, minstret_reg[DATA_WIDTH-1:0]};
                default: ;
            endcase
        end
    end

    // FSM next state and redirect outputs.
    always_comb begin
        state_next     = state_reg;
        commit_ready   = 1'b0;
        exception      = 1'b0;
        mret_out       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_reg)
            ST_RUN: begin
                commit_ready = 1'b1;
                if (accept && exception_valid)
                    state_next = ST_TRAP;
                else if (accept && is_mret)
                    state_next = ST_RET;
            end
            ST_TRAP: begin
                exception      = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = mtvec_reg;
                state_next     = ST_RUN;
            end
            ST_RET: begin
                mret_out       = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = mepc_reg;
                state_next     = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_RUN;
            mie_reg      <= 1'b0;
            mpie_reg     <= 1'b0;
            mpp_reg      <= 2'b11;
            mtvec_reg    <= RESET_MTVEC;
            mscratch_reg <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            state_reg    <= state_next;
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;
            if (state_reg == ST_RET) begin
                // MPP is still visible during the RET cycle; restore on exit.
                mie_reg  <= mpie_reg;
                mpie_reg <= 1'b1;
                mpp_reg  <= 2'b00;
            end else if (accept && exception_valid) begin
                mepc_reg   <= commit_pc & ALIGN4;
                mcause_reg <= exception_cause;
                mpie_reg   <= mie_reg;
                mie_reg    <= 1'b0;
                mpp_reg    <= current_privilege;
            end else if (write_en) begin
                case (csr_addr)
                    12'h300: begin
                        mie_reg  <= write_data[3];
                        mpie_reg <= write_data[7];
                        // Only U (00) and M (11) exist; other encodings are dropped.
                        if ((write_data[12:11] == 2'b00) || (write_data[12:11] == 2'b11))
                            mpp_reg <= write_data[12:11];
                    end
                    12'h305: mtvec_reg    <= write_data & ALIGN4;
                    12'h340: mscratch_reg <= write_data;
                    12'h341: mepc_reg     <= write_data & ALIGN4;
                    12'h342: mcause_reg   <= write_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_unit -- scoreboard bench for csr_unit.
// The stimulus process drives one commit per cycle, evaluates a behavioural
// CSR model and queues the expected responses; a negedge monitor pops and
// compares them against what the DUT presents.
// ---------------------------------------------------------------------------
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, commit_ready;
    logic [31:0] commit_pc;
    logic        is_csr;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_val;
    logic        exception_valid;
    logic [31:0] exception_cause;
    logic        is_mret;
    logic [1:0]  current_privilege;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] mstatus;
    logic        exception, mret_out, redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    csr_unit dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pc(commit_pc), .is_csr(is_csr), .csr_op(csr_op),
        .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_val(rs1_val),
        .exception_valid(exception_valid), .exception_cause(exception_cause),
        .is_mret(is_mret), .current_privilege(current_privilege),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .mstatus(mstatus),
        .exception(exception), .mret_out(mret_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] rdata; logic illegal; } cexp_t;
    typedef struct { logic exc; logic mret; logic [31:0] pc; } rexp_t;
    cexp_t cq[$];
    rexp_t rq[$];
    cexp_t mon_c;
    rexp_t mon_r;

    // Architectural model: current values and values after the coming edge.
    logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;
    int          m_mode;      // 0 running, 1 trap redirect, 2 mret redirect
    logic [31:0] n_mstatus, n_mtvec, n_mscratch, n_mepc, n_mcause;
    logic [63:0] n_mcycle, n_minstret;
    int          n_mode;
    logic        mon_en = 1'b0;

    logic [11:0] addr_pool [12] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h123};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mstatus = 32'h1800; m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_mcycle = 0; m_minstret = 0; m_mode = 0;
        cq.delete();
        rq.delete();
    endtask

    task automatic model_read(input logic [11:0] a, output logic ok, output logic [31:0] v);
        ok = 1'b1;
        v  = 32'h0;
        case (a)
            12'h300: v = m_mstatus;
            12'h301: v = 32'h4000_1100;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'hB00: v = m_mcycle[31:0];
            12'hB80: v = m_mcycle[63:32];
            12'hB02: v = m_minstret[31:0];
            12'hB82: v = m_minstret[63:32];
            default: ok = 1'b0;
        endcase
    endtask

    task automatic model_write(input logic [11:0] a, input logic [31:0] w);
        case (a)
            12'h300: n_mstatus = (w & 32'h88) |
                     (((w[12:11] == 2'b01) || (w[12:11] == 2'b10)) ? (m_mstatus & 32'h1800)
                                                                    : (w & 32'h1800));
            12'h305: n_mtvec    = w & ~32'd3;
            12'h340: n_mscratch = w;
            12'h341: n_mepc     = w & ~32'd3;
            12'h342: n_mcause   = w;
            12'hB00: n_mcycle   = {m_mcycle[63:32], w};
            12'hB80: n_mcycle   = {w, m_mcycle[31:0]};
            12'hB02: n_minstret = {m_minstret[63:32], w};
            12'hB82: n_minstret = {w, m_minstret[31:0]};
            default: ;
        endcase
    endtask

    // Drive one cycle of inputs, predict the response and the next state.
    task automatic issue(input logic v, input logic ic, input logic [2:0] op,
                         input logic [11:0] a, input logic [4:0] idx, input logic [31:0] val,
                         input logic exc, input logic [31:0] cause, input logic mr,
                         input logic [1:0] priv, input logic [31:0] pc);
        logic        ok, acc;
        logic [31:0] old, opnd, wv;
        cexp_t       ce;
        rexp_t       re;
        commit_valid = v; is_csr = ic; csr_op = op; csr_addr = a; rs1_idx = idx;
        rs1_val = val; exception_valid = exc; exception_cause = cause; is_mret = mr;
        current_privilege = priv; commit_pc = pc;

        n_mstatus = m_mstatus; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
        n_mepc = m_mepc; n_mcause = m_mcause; n_minstret = m_minstret;
        n_mcycle = m_mcycle + 64'd1;
        n_mode = 0;
        if (m_mode == 2)
            n_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);

        acc = v && (m_mode == 0);
        model_read(a, ok, old);
        if (acc) begin
            ce.rdata   = (ic && ok) ? old : 32'h0;
            ce.illegal = ic && !exc && !ok;
            cq.push_back(ce);
            if (exc) begin
                n_mepc    = pc & ~32'd3;
                n_mcause  = cause;
                n_mstatus = (m_mstatus[3] ? 32'h80 : 32'h0) | (32'(priv) << 11);
                n_mode    = 1;
                re.exc = 1'b1; re.mret = 1'b0; re.pc = n_mtvec;
                rq.push_back(re);
            end else begin
                n_minstret = m_minstret + 64'd1;
                if (ic && ok && (op == 3'd1 || op == 3'd5 || idx != 5'd0)) begin
                    opnd = op[2] ? {27'h0, idx} : val;
                    case (op[1:0])
                        2'b01:   wv = opnd;
                        2'b10:   wv = old | opnd;
                        default: wv = old & ~opnd;
                    endcase
                    model_write(a, wv);
                end
                if (mr) begin
                    n_mode = 2;
                    re.exc = 1'b0; re.mret = 1'b1; re.pc = n_mepc;
                    rq.push_back(re);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_mstatus = n_mstatus; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
        m_mepc = n_mepc; m_mcause = n_mcause; m_mcycle = n_mcycle;
        m_minstret = n_minstret; m_mode = n_mode;
    endtask

    task automatic csr_cmd(input logic [2:0] op, input logic [11:0] a,
                           input logic [4:0] idx, input logic [31:0] val);
        issue(1'b1, 1'b1, op, a, idx, val, 1'b0, 32'h0, 1'b0, 2'b11, 32'h0);
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 3'd0, 12'h0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b11, 32'h0);
    endtask

    // Monitor: compares everything the DUT presents each cycle.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            chk("commit_ready", 32'(commit_ready), 32'(m_mode == 0));
            chk("mstatus", mstatus, m_mstatus);
            if (commit_valid && commit_ready) begin
                if (cq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL commit_queue: got unexpected commit expected none");
                end else begin
                    mon_c = cq.pop_front();
                    chk("csr_rdata", csr_rdata, mon_c.rdata);
                    chk("csr_illegal", 32'(csr_illegal), 32'(mon_c.illegal));
                end
            end else begin
                chk("idle_rdata", csr_rdata, 32'h0);
                chk("idle_illegal", 32'(csr_illegal), 32'h0);
            end
            if (m_mode != 0) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL redirect_queue: got redirect cycle expected none");
                end else begin
                    mon_r = rq.pop_front();
                    chk("redirect_valid", 32'(redirect_valid), 32'h1);
                    chk("exception", 32'(exception), 32'(mon_r.exc));
                    chk("mret_out", 32'(mret_out), 32'(mon_r.mret));
                    chk("redirect_pc", redirect_pc, mon_r.pc);
                end
            end else begin
                chk("run_redirect_valid", 32'(redirect_valid), 32'h0);
                chk("run_exception", 32'(exception), 32'h0);
                chk("run_mret_out", 32'(mret_out), 32'h0);
                chk("run_redirect_pc", redirect_pc, 32'h0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_ic, r_mr, r_exc;
        logic [2:0]  r_op;
        logic [4:0]  r_idx;
        int unsigned r;

        rst = 1'b0;
        commit_valid = 0; commit_pc = 0; is_csr = 0; csr_op = 0; csr_addr = 0;
        rs1_idx = 0; rs1_val = 0; exception_valid = 0; exception_cause = 0;
        is_mret = 0; current_privilege = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        mon_en = 1'b1;
        chk("rst_mstatus", mstatus, 32'h1800);
        chk("rst_ready", 32'(commit_ready), 32'h1);
        chk("rst_redirect", 32'(redirect_valid), 32'h0);
        chk("rst_exception", 32'(exception), 32'h0);

        csr_cmd(3'd2, 12'h305, 5'd0, 32'h0);   #1 chk("rst_mtvec", csr_rdata, 32'h100); tick();
        csr_cmd(3'd2, 12'h342, 5'd0, 32'h0);   #1 chk("rst_mcause", csr_rdata, 32'h0);  tick();

        // mcycle low half carry into the high half.
        csr_cmd(3'd1, 12'hB00, 5'd1, 32'hFFFF_FFFF); tick();
        idle(); tick();
        idle(); tick();
        csr_cmd(3'd2, 12'hB00, 5'd0, 32'h0); #1 chk("mcycle_lo", csr_rdata, 32'h1); tick();
        csr_cmd(3'd2, 12'hB80, 5'd0, 32'h0); #1 chk("mcycle_hi", csr_rdata, 32'h1); tick();

        // mscratch write, then read-only set.
        csr_cmd(3'd1, 12'h340, 5'd1, 32'hDEAD_BEEF); tick();
        csr_cmd(3'd2, 12'h340, 5'd0, 32'hFFFF_FFFF); #1 chk("mscratch_rs0", csr_rdata, 32'hDEAD_BEEF); tick();
        csr_cmd(3'd2, 12'h340, 5'd0, 32'h0);         #1 chk("mscratch_keep", csr_rdata, 32'hDEAD_BEEF); tick();

        // Unimplemented address.
        csr_cmd(3'd2, 12'h7C0, 5'd3, 32'h5);
        #1 chk("illegal_pulse", 32'(csr_illegal), 32'h1); chk("illegal_rdata", csr_rdata, 32'h0);
        tick();
        idle(); #1 chk("illegal_clear", 32'(csr_illegal), 32'h0); tick();

        // Trap entry.
        csr_cmd(3'd1, 12'h305, 5'd1, 32'h200); tick();
        csr_cmd(3'd6, 12'h300, 5'd8, 32'h0);   tick();
        issue(1'b1, 1'b0, 3'd0, 12'h0, 5'd0, 32'h0, 1'b1, 32'd11, 1'b0, 2'b11, 32'h104); tick();
        idle();
        #1 chk("trap_exception", 32'(exception), 32'h1);
        chk("trap_pc", redirect_pc, 32'h200);
        chk("trap_mstatus", mstatus, 32'h1880);
        tick();
        csr_cmd(3'd2, 12'h341, 5'd0, 32'h0); #1 chk("trap_mepc", csr_rdata, 32'h104); tick();
        csr_cmd(3'd2, 12'h342, 5'd0, 32'h0); #1 chk("trap_mcause", csr_rdata, 32'd11); tick();

        // MRET.
        csr_cmd(3'd1, 12'h341, 5'd1, 32'h80); tick();
        issue(1'b1, 1'b0, 3'd0, 12'h0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b11, 32'h300); tick();
        idle();
        #1 chk("ret_mret_out", 32'(mret_out), 32'h1);
        chk("ret_pc", redirect_pc, 32'h80);
        chk("ret_mpp", 32'(mstatus[12:11]), 32'h3);
        tick();
        idle(); #1 chk("ret_mstatus_after", mstatus, 32'h88); tick();

        // Reset while in TRAP.
        issue(1'b1, 1'b0, 3'd0, 12'h0, 5'd0, 32'h0, 1'b1, 32'd2, 1'b0, 2'b00, 32'h400); tick();
        idle();
        #1 rst = 1'b0;
        #1 chk("rst_trap_exception", 32'(exception), 32'h0);
        chk("rst_trap_redirect", 32'(redirect_valid), 32'h0);
        chk("rst_trap_ready", 32'(commit_ready), 32'h1);
        chk("rst_trap_mstatus", mstatus, 32'h1800);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        csr_cmd(3'd2, 12'h341, 5'd0, 32'h0); #1 chk("rst_trap_mepc", csr_rdata, 32'h0); tick();

        // Randomized commits.
        for (int i = 0; i < 1500; i++) begin
            r     = $urandom_range(0, 5);
            r_op  = 3'((r < 3) ? r + 1 : r + 2);
            r_idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r_ic  = ($urandom_range(0, 9) < 7);
            r_exc = ($urandom_range(0, 11) == 0);
            r_mr  = !r_ic && ($urandom_range(0, 2) == 0);
            issue(($urandom_range(0, 9) < 8), r_ic, r_op, addr_pool[$urandom_range(0, 11)],
                  r_idx, $urandom, r_exc, $urandom, r_mr,
                  ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, $urandom);
            tick();
        end

        idle(); tick();
        idle(); tick();
        chk("commit_queue_drained", 32'(cq.size()), 32'h0);
        chk("redirect_queue_drained", 32'(rq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
